// File: rtl/reversi_pkg.sv
// reversi_pkg: shared board definitions for the move scanner.
//   - 2-bit cell encoding (EMPTY, ENABLE, BLACK, WHITE)
//   - scanner FSM state type
//   - per-direction row/column deltas, in the scan order N, NE, E, SE, S, SW, W, NW
//   - cell index helper (row*8+col) and a cell extractor for the 128-bit board
//   - starting board constant
package reversi_pkg;

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] ENABLE = 2'd1;
    localparam logic [1:0] BLACK  = 2'd2;
    localparam logic [1:0] WHITE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_DONE
    } scan_state_t;

    // Two's complement 2-bit deltas: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1
    localparam logic signed [1:0] DROW [8] = '{2'sb11, 2'sb11, 2'sb00, 2'sb01,
                                               2'sb01, 2'sb01, 2'sb00, 2'sb11};
    localparam logic signed [1:0] DCOL [8] = '{2'sb00, 2'sb01, 2'sb01, 2'sb01,
                                               2'sb00, 2'sb11, 2'sb11, 2'sb11};

    // White at (3,3),(4,4); black at (3,4),(4,3)
    localparam logic [127:0] INIT_BOARD = (128'd3 << 54) | (128'd2 << 56) |
                                          (128'd2 << 70) | (128'd3 << 72);

    function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
        return {r, c};
    endfunction

    function automatic logic [1:0] cell_at(input logic [127:0] b, input logic [5:0] idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/dir_stepper.sv
// dir_stepper: combinational one-cell step from a cursor in a given direction.
// Ports:
//   i_row, i_col   current cursor
//   i_dir          direction 0..7 (N, NE, E, SE, S, SW, W, NW)
//   o_row, o_col   stepped cursor (meaningless when o_off_board is set)
//   o_off_board    step left the 8x8 board
module dir_stepper
    import reversi_pkg::*;
(
    input  logic [2:0] i_row,
    input  logic [2:0] i_col,
    input  logic [2:0] i_dir,
    output logic [2:0] o_row,
    output logic [2:0] o_col,
    output logic       o_off_board
);

    logic [1:0] w_drow;
    logic [1:0] w_dcol;
    logic [3:0] w_row;
    logic [3:0] w_col;

    assign w_drow = DROW[i_dir];
    assign w_dcol = DCOL[i_dir];

    // 4-bit sum: -1 wraps to 4'b1111 and 8 is 4'b1000, so bit 3 flags both exits
    assign w_row = {1'b0, i_row} + {{2{w_drow[1]}}, w_drow};
    assign w_col = {1'b0, i_col} + {{2{w_dcol[1]}}, w_dcol};

    assign o_row       = w_row[2:0];
    assign o_col       = w_col[2:0];
    assign o_off_board = w_row[3] | w_col[3];

endmodule

// File: rtl/move_scanner.sv
// move_scanner: checks a proposed move against a snapshot of the board,
// walking all 8 directions one probe per cycle, and reports legality,
// a 64-bit flip mask and its popcount.
//
// state | meaning
// IDLE  | waiting for start; results from the last scan held
// CHECK | target cell tested for vacancy
// SCAN  | one probe per cycle along the current direction
// DONE  | done pulse; legal/flip_mask/flip_count valid
//
// Ports:
//   clk          system clock
//   resetn       asynchronous reset, active HIGH despite the name
//   board_state  128-bit board, cell i at bits [2i+1:2i]
//   start        request, accepted only in IDLE; row/col/player sampled with it
//   busy         high from the accepting edge until done
//   done         one-cycle result strobe
//   legal, flip_mask, flip_count   results, held until the next accept
module move_scanner
    import reversi_pkg::*;
#(
    parameter int N_DIRS = 8,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [127:0]     board_state,
    input  logic             start,
    input  logic [2:0]       row,
    input  logic [2:0]       col,
    input  logic             player,
    output logic             busy,
    output logic             done,
    output logic             legal,
    output logic [63:0]      flip_mask,
    output logic [CNT_W-1:0] flip_count
);

    scan_state_t      r_state;
    scan_state_t      w_next_state;

    logic [127:0]     r_snap;
    logic [2:0]       r_row;
    logic [2:0]       r_col;
    logic             r_player;
    logic [2:0]       r_dir;
    logic [2:0]       r_cur_row;
    logic [2:0]       r_cur_col;
    logic [63:0]      r_tent;
    logic [CNT_W-1:0] r_tcnt;
    logic [63:0]      r_mask;
    logic [CNT_W-1:0] r_count;
    logic             r_legal;

    logic [2:0]       w_step_row;
    logic [2:0]       w_step_col;
    logic             w_off;
    logic [5:0]       w_probe_idx;
    logic [1:0]       w_probe_cell;
    logic [1:0]       w_target_cell;
    logic [1:0]       w_own;
    logic [1:0]       w_opp;
    logic             w_vacant;
    logic             w_extend;
    logic             w_commit;
    logic             w_last_dir;
    logic [63:0]      w_mask_next;
    logic             w_busy;
    logic             w_done;

    dir_stepper u_stepper (
        .i_row       (r_cur_row),
        .i_col       (r_cur_col),
        .i_dir       (r_dir),
        .o_row       (w_step_row),
        .o_col       (w_step_col),
        .o_off_board (w_off)
    );

    assign w_probe_idx   = cell_idx(w_step_row, w_step_col);
    assign w_probe_cell  = cell_at(r_snap, w_probe_idx);
    assign w_target_cell = cell_at(r_snap, cell_idx(r_row, r_col));
    assign w_vacant      = (w_target_cell == EMPTY) || (w_target_cell == ENABLE);
    assign w_own         = r_player ? BLACK : WHITE;
    assign w_opp         = r_player ? WHITE : BLACK;

    // Opponent cell extends the run; anything else ends this direction,
    // and only an own-colour cell keeps the run.
    assign w_extend    = !w_off && (w_probe_cell == w_opp);
    assign w_commit    = !w_off && (w_probe_cell == w_own);
    assign w_last_dir  = (r_dir == 3'(N_DIRS - 1));
    assign w_mask_next = r_mask | (w_commit ? r_tent : 64'd0);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_busy       = 1'b1;
                w_next_state = w_vacant ? ST_SCAN : ST_DONE;
            end
            ST_SCAN: begin
                w_busy = 1'b1;
                if (!w_extend && w_last_dir) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_snap    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_player  <= 1'b0;
            r_dir     <= '0;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_tent    <= '0;
            r_tcnt    <= '0;
            r_mask    <= '0;
            r_count   <= '0;
            r_legal   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap    <= board_state;
                        r_row     <= row;
                        r_col     <= col;
                        r_player  <= player;
                        r_dir     <= '0;
                        r_cur_row <= row;
                        r_cur_col <= col;
                        r_tent    <= '0;
                        r_tcnt    <= '0;
                        r_mask    <= '0;
                        r_count   <= '0;
                        r_legal   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_extend) begin
                        r_tent    <= r_tent | (64'd1 << w_probe_idx);
                        r_tcnt    <= r_tcnt + CNT_W'(1);
                        r_cur_row <= w_step_row;
                        r_cur_col <= w_step_col;
                    end else begin
                        if (w_commit) begin
                            r_mask  <= w_mask_next;
                            r_count <= r_count + r_tcnt;
                        end
                        // Legality is latched on the final probe so it is
                        // already valid in the DONE cycle.
                        if (w_last_dir) begin
                            r_legal <= (w_mask_next != 64'd0);
                        end
                        r_dir     <= r_dir + 3'd1;
                        r_cur_row <= r_row;
                        r_cur_col <= r_col;
                        r_tent    <= '0;
                        r_tcnt    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = w_busy;
    assign done       = w_done;
    assign legal      = r_legal;
    assign flip_mask  = r_mask;
    assign flip_count = r_count;

endmodule

// File: doc/move_scanner.md
Name: move_scanner

Overview:
- Downstream consumer of the board's cell-state array.
- Given a proposed move (row, col, player), it walks all 8 directions one cell per cycle over a snapshot of the board.
- It reports legality, a 64-bit flip mask and a flip count.
- The board's play/update logic uses the mask to commit the move.

Parameters:
- N_DIRS, 8, number of scan directions (fixed; not intended to change).
- CNT_W, 6, width of flip_count.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  reset; asynchronous, active-high (high = reset) despite the name, matching the board's node convention.
- board_state  input  128  cell i = row*8+col occupies bits [2i+1:2i]. Encoding: 0 EMPTY, 1 ENABLE, 2 BLACK, 3 WHITE. Row 0 is the top row.
- start  input  1  request pulse; accepted only in IDLE.
- row  input  3  target row, sampled with start.
- col  input  3  target column, sampled with start.
- player  input  1  1 = black, 0 = white; sampled with start.
- busy  output  1  high from the accepting edge until done.
- done  output  1  one-cycle pulse when results are valid.
- legal  output  1  valid with done; held until the next accept.
- flip_mask  output  64  bit i set = cell i flips; held until the next accept.
- flip_count  output  CNT_W  popcount of flip_mask; held until the next accept.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, snapshot cleared. Reset asserted mid-scan aborts immediately with no done pulse.
- States: IDLE, CHECK, SCAN, DONE.
- IDLE:
  - start=1 captures board_state into a 128-bit snapshot, along with row, col, player.
  - Clears flip_mask, flip_count and legal; sets busy; goes to CHECK.
- CHECK (1 cycle):
  - Target EMPTY or ENABLE: vacant. Go to SCAN with dir=0, cursor=target, tentative mask=0.
  - Otherwise (BLACK or WHITE): go to DONE with legal=0.
- Direction order: 0 N(-1,0), 1 NE(-1,+1), 2 E(0,+1), 3 SE(+1,+1), 4 S(+1,0), 5 SW(+1,-1), 6 W(0,-1), 7 NW(-1,-1).
- SCAN probes one cell per cycle: cursor+delta[dir].
  - Off-board (row or col leaves 0..7) or cell EMPTY/ENABLE: discard tentative, advance dir.
  - Opponent colour: OR the cell into tentative, advance cursor, stay on same dir.
  - Own colour: OR tentative into flip_mask, add its popcount to flip_count, advance dir.
  - Advancing dir resets cursor to target and tentative to 0. After dir 7 resolves, go to DONE.
- DONE (1 cycle): done=1; legal=(flip_mask!=0); busy drops; return to IDLE.
- Latency: P = total probes (one per cell probed, minimum 1 per direction, so 8 ≤ P ≤ 56).
  - Vacant target: done in cycle 2+P after the accepting edge.
  - Occupied target: done in cycle 2.
- start while busy is ignored; no queueing. start in the DONE cycle is also ignored.
- The snapshot isolates the scan from board_state changes during busy.
- flip_count never exceeds 18 in legal play; CNT_W=6 avoids overflow for any 64-cell input.

Decomposition:
- Package reversi_pkg:
  - Cell encoding constants EMPTY/ENABLE/BLACK/WHITE.
  - Direction delta tables (drow, dcol as signed 2-bit).
  - Cell-index function row*8+col.
  - Initial-board constant.
- Sub-module dir_stepper: combinational. Takes cursor (row, col) and dir; returns next (row, col) and an off_board flag. Keeps the FSM free of wrap logic.

Test Plan:
- Initial board (W at (3,3),(4,4); B at (3,4),(4,3)); black plays (2,3) -> P=9, done at cycle 11; legal=1; flip_mask bit 27 only; flip_count=1.
- Initial board; start on occupied (3,3) -> done at cycle 2; legal=0; mask=0; count=0.
- Initial board; black plays corner (0,0) -> five off-board and three empty directions, P=8, done at cycle 10, legal=0.
- Row 0: W at c1..c6, B at c7; black plays (0,0) -> flip_mask bits 1..6, flip_count=6, legal=1. Repeat with c7 EMPTY -> legal=0.
- start pulsed again at cycle 4 of a scan -> ignored; results match the single-request run. Change board_state mid-scan -> results unchanged.
- resetn asserted at cycle 5 of a scan -> busy, done, legal, mask and count all 0 immediately. Next start runs cleanly.
